// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver: register map, control bits,
// scan state and the active-high hex-to-segment table.
package seg_pkg;
  localparam logic [1:0] ADDR_DIGITS = 2'd0;
  localparam logic [1:0] ADDR_DP     = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_SCAN_EN = 0;
  localparam int CTRL_RAW     = 1;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_e;

  // Segment order {g,f,e,d,c,b,a}; entry 0 sits in the low slice.
  localparam logic [15:0][6:0] HEX7_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg_hex_decoder.sv
// Nibble to active-high 7-segment pattern; polarity is handled by the caller.
module seg_hex_decoder (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  import seg_pkg::*;

  assign seg = HEX7_TBL[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// Three-digit common-anode scan driver with double-buffered digit/dp registers,
// per-slot blanking and frame-aligned shadow updates.
module seg_scan_driver #(
  parameter int SCAN_DIV         = 50000,
  parameter int BLANK_CYCLES     = 64,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [2:0]  seg_en_in,
  output logic [2:0]  digit_sel,
  output logic [7:0]  seg_out,
  output logic        frame_tick
);
  import seg_pkg::*;

  localparam int             CW         = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]     DIG_OFF    = DIGIT_ACTIVE_LOW ? 3'b111 : 3'b000;
  localparam logic [7:0]     SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [11:0]   pending, shadow;
  logic [2:0]    pending_dp, shadow_dp;
  logic [1:0]    ctrl;
  logic [7:0]    frame_cnt;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  scan_state_e   state;
  logic          en_q;

  logic          wr_en, term, frame_end, drive_on, cur_dp;
  logic [3:0]    cur_nib;
  logic [6:0]    dec7;
  logic [7:0]    seg_raw;
  logic [2:0]    dig_onehot;
  logic          unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign term         = (cnt == CNT_LAST);
  assign frame_end    = term && (idx == 2'd2);
  assign unused_wdata = ^writedata[31:12];

  always_comb begin
    cur_nib = shadow[3:0];
    case (idx)
      2'd1:    cur_nib = shadow[7:4];
      2'd2:    cur_nib = shadow[11:8];
      default: cur_nib = shadow[3:0];
    endcase
  end

  assign cur_dp = shadow_dp[idx];

  seg_hex_decoder u_dec (
    .nib (cur_nib),
    .seg (dec7)
  );

  // Raw mode is a debug view: the nibble itself lands on segments a..d.
  assign seg_raw    = ctrl[CTRL_RAW] ? {cur_dp, 3'b000, cur_nib} : {cur_dp, dec7};
  assign dig_onehot = 3'b001 << idx;
  assign drive_on   = (state == DRIVE) && ctrl[CTRL_SCAN_EN] && en_q;

  // Register file; the shadow load uses the pre-write pending value when a
  // write lands on the frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      pending_dp <= '0;
      ctrl       <= 2'b01;
      shadow     <= '0;
      shadow_dp  <= '0;
      frame_cnt  <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DIGITS: pending    <= writedata[11:0];
          ADDR_DP:     pending_dp <= writedata[2:0];
          ADDR_CTRL:   ctrl       <= writedata[1:0];
          default:     ;
        endcase
      end
      if (frame_end) begin
        shadow    <= pending;
        shadow_dp <= pending_dp;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Slot scanner; outputs are registered from the current slot position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= BLANK;
      en_q       <= 1'b0;
      digit_sel  <= DIG_OFF;
      seg_out    <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (cnt == '0) en_q <= seg_en_in[idx];
      if (term) begin
        cnt   <= '0;
        idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        state <= BLANK;
      end else begin
        cnt <= cnt + CW'(1);
        if (cnt == BLANK_LAST) state <= DRIVE;
      end
      digit_sel <= drive_on ? (DIGIT_ACTIVE_LOW ? ~dig_onehot : dig_onehot) : DIG_OFF;
      seg_out   <= (state == DRIVE) ? (SEG_ACTIVE_LOW ? ~seg_raw : seg_raw) : SEG_OFF;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DIGITS: readdata[11:0] = pending;
      ADDR_DP:     readdata[2:0]  = pending_dp;
      ADDR_CTRL:   readdata[1:0]  = ctrl;
      default: begin
        readdata[15:8] = frame_cnt;
        readdata[4]    = state;
        readdata[1:0]  = idx;
      end
    endcase
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with an 8-cycle slot and 2-cycle blanking.
module tb_seg_scan_driver;
  logic        clk, reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic [2:0]  seg_en_in, digit_sel;
  logic [7:0]  seg_out;
  logic        frame_tick;

  int ncmp = 0;
  int nerr = 0;

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_en_in  (seg_en_in),
    .digit_sel  (digit_sel),
    .seg_out    (seg_out),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Returns the number of edges until frame_tick is seen, or 999 on timeout.
  task automatic wait_tick(output int n);
    n = 999;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (frame_tick) begin n = i; break; end
    end
  endtask

  // Checks one full frame starting just after a frame_tick edge. Digit s is
  // driven on edges 8s+3..8s+8; optional write at edge wr_k+1, enable change after edge chg_k.
  task automatic run_frame(input logic [7:0] s0, s1, s2, input logic [2:0] en,
                           input int wr_k, input logic [11:0] wval,
                           input int chg_k, input logic [2:0] chg_en);
    int p, s;
    logic [2:0] oh, exp_sel;
    logic [7:0] exp_seg;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (k == wr_k + 1) begin chipselect = 1'b0; write_n = 1'b1; end
      p = (k - 1) % 8;
      s = (k - 1) / 8;
      oh = 3'b001 << s;
      exp_sel = (p >= 2 && en[s]) ? ~oh : 3'b111;
      exp_seg = (p < 2) ? 8'hFF : (s == 0) ? s0 : (s == 1) ? s1 : s2;
      chk($sformatf("digit_sel k%0d", k), {29'd0, digit_sel}, {29'd0, exp_sel});
      chk($sformatf("seg_out k%0d", k), {24'd0, seg_out}, {24'd0, exp_seg});
      chk($sformatf("frame_tick k%0d", k), {31'd0, frame_tick}, {31'd0, (k == 24)});
      if (k == wr_k) begin
        address = 2'd0; writedata = {20'd0, wval}; chipselect = 1'b1; write_n = 1'b0;
      end
      if (k == chg_k) seg_en_in = chg_en;
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0; address = 2'd2; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; seg_en_in = 3'b111;

    // 1: reset state and first frame_tick distance
    repeat (3) @(posedge clk);
    #1;
    chk("rst digit_sel", {29'd0, digit_sel}, 32'h7);
    chk("rst seg_out", {24'd0, seg_out}, 32'hFF);
    chk("rst frame_tick", {31'd0, frame_tick}, 32'h0);
    chk("rst ctrl", readdata, 32'h1);
    reset_n = 1'b1;
    wait_tick(n);
    chk("first tick dist", n, 24);
    address = 2'd3; #1;
    chk("status after 1st frame", readdata, 32'h100);

    // 2: digits 3A1, dp on digit1
    bus_wr(2'd0, 32'h3A1);
    bus_wr(2'd1, 32'h2);
    address = 2'd0; #1;
    chk("rd digits", readdata, 32'h3A1);
    address = 2'd1; #1;
    chk("rd dp", readdata, 32'h2);
    wait_tick(n);
    chk("tick dist after writes", n, 22);
    run_frame(8'hF9, 8'h08, 8'hB0, 3'b111, -10, 12'h0, -10, 3'b0);

    // 3: digit1 masked, slot timing unchanged
    seg_en_in = 3'b101;
    run_frame(8'hF9, 8'h08, 8'hB0, 3'b101, -10, 12'h0, -10, 3'b0);

    // 4: write on the frame boundary is deferred one frame
    seg_en_in = 3'b111;
    run_frame(8'hF9, 8'h08, 8'hB0, 3'b111, 23, 12'h555, -10, 3'b0);
    address = 2'd0; #1;
    chk("rd digits 555", readdata, 32'h555);
    run_frame(8'hF9, 8'h08, 8'hB0, 3'b111, -10, 12'h0, -10, 3'b0);

    // 5: digit0 enable dropped mid-drive holds to slot end
    run_frame(8'h92, 8'h12, 8'h92, 3'b111, -10, 12'h0, 5, 3'b110);
    run_frame(8'h92, 8'h12, 8'h92, 3'b110, -10, 12'h0, -10, 3'b0);

    // 6: reset mid-drive, then scanning disabled
    seg_en_in = 3'b111;
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset digit0 on", {29'd0, digit_sel}, 32'h6);
    reset_n = 1'b0; #1;
    chk("mid rst digit_sel", {29'd0, digit_sel}, 32'h7);
    chk("mid rst seg_out", {24'd0, seg_out}, 32'hFF);
    chk("mid rst frame_tick", {31'd0, frame_tick}, 32'h0);
    address = 2'd3; #1;
    chk("mid rst status", readdata, 32'h0);
    #2 reset_n = 1'b1; #1;
    chk("post rst status", readdata, 32'h0);
    address = 2'd2; #1;
    chk("post rst ctrl", readdata, 32'h1);
    address = 2'd0; #1;
    chk("post rst digits", readdata, 32'h0);
    bus_wr(2'd2, 32'h0);
    for (int i = 2; i <= 48; i++) begin
      @(posedge clk); #1;
      chk($sformatf("scan off sel e%0d", i), {29'd0, digit_sel}, 32'h7);
      if (i == 24 || i == 48) chk($sformatf("scan off tick e%0d", i), {31'd0, frame_tick}, 32'h1);
    end
    address = 2'd3; #1;
    chk("status 2 frames", readdata, 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
